// File: rtl/k_ctrl_pkg.sv
// Shared types, limits and default parameters for the gain-constant key controller.
package k_ctrl_pkg;

    localparam int unsigned K_W = 8;
    localparam logic [K_W-1:0] K_MIN = 8'd0;
    localparam logic [K_W-1:0] K_MAX = 8'd255;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY = 25000000;
    localparam int unsigned DEF_REPEAT_RATE = 5000000;
    localparam logic [K_W-1:0] DEF_K_INIT = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } kState_e;

    // Saturating +1 / -1 step of the gain constant.
    function automatic logic [K_W-1:0] kStep(input logic [K_W-1:0] k, input logic dec);
        if (dec) begin
            return (k == K_MIN) ? k : k - K_W'(1);
        end
        return (k == K_MAX) ? k : k + K_W'(1);
    endfunction

endpackage

// File: rtl/k_const_ctrl_if.sv
// Key/switch inputs and gain outputs of the gain-constant controller.
interface k_const_ctrl_if;
    import k_ctrl_pkg::*;

    logic           iKEY;
    logic           iEN_SW;
    logic           iDEC_SW;
    logic [K_W-1:0] oK;
    logic           oK_UPD;
    logic           oSAT;

    modport master (output iKEY, output iEN_SW, output iDEC_SW,
                    input  oK,   input  oK_UPD, input  oSAT);
    modport slave  (input  iKEY, input  iEN_SW, input  iDEC_SW,
                    output oK,   output oK_UPD, output oSAT);
endinterface

// File: rtl/k_const_ctrl_key_debounce.sv
// Synchronizes the raw active-low pushbutton and debounces it into a level plus edge pulses.
module key_debounce
    import k_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iKEY,
    output logic oLevel,
    output logic oPress,
    output logic oRelease
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, idles at the released level.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= iKEY;
            sync2 <= sync1;
        end
    end

    // Flip the level after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreeing sample restarts.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oLevel   <= 1'b1;
            cnt      <= '0;
            oPress   <= 1'b0;
            oRelease <= 1'b0;
        end else begin
            oPress   <= 1'b0;
            oRelease <= 1'b0;
            if (sync2 == oLevel) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt      <= '0;
                oLevel   <= sync2;
                oPress   <= ~sync2;
                oRelease <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/k_const_ctrl.sv
// Pushbutton-driven gain constant with debounce, auto-repeat and saturation.
module k_const_ctrl
    import k_ctrl_pkg::*;
#(
    parameter int unsigned    DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned    REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned    REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [K_W-1:0] K_INIT          = DEF_K_INIT
) (
    input  logic          iCLK,
    input  logic          iRST,
    k_const_ctrl_if.slave keyBus
);

    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    logic             keyLevel;
    logic             pressPulse;
    logic             relPulse;
    kState_e          state;
    kState_e          stateNext;
    logic [TMR_W-1:0] timer;
    logic             tmrClr;
    logic             stepReq;
    logic             exitHold;
    logic             held;
    logic             delayDone;
    logic             rateDone;
    logic [K_W-1:0]   kReg;
    logic [K_W-1:0]   kNext;
    logic             kUpd;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iKEY    (keyBus.iKEY),
        .oLevel  (keyLevel),
        .oPress  (pressPulse),
        .oRelease(relPulse)
    );

    assign held      = ~keyLevel;
    assign exitHold  = relPulse | ~keyBus.iEN_SW;
    assign delayDone = (timer == TMR_W'(REPEAT_DELAY - 1));
    assign rateDone  = (timer == TMR_W'(REPEAT_RATE - 1));

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: press starts a hold, release or disable ends it from anywhere.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (pressPulse && keyBus.iEN_SW) stateNext = ST_FIRST;
            end
            ST_FIRST: begin
                if (exitHold)       stateNext = ST_IDLE;
                else if (delayDone) stateNext = ST_REPEAT;
            end
            ST_REPEAT: begin
                if (exitHold) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // FSM outputs: step requests and repeat-timer restart.
    always_comb begin
        stepReq = 1'b0;
        tmrClr  = 1'b1;
        case (state)
            ST_IDLE: begin
                stepReq = pressPulse & keyBus.iEN_SW;
            end
            ST_FIRST: begin
                if (!exitHold) begin
                    tmrClr  = delayDone;
                    stepReq = delayDone & held;
                end
            end
            ST_REPEAT: begin
                if (!exitHold) begin
                    tmrClr  = rateDone;
                    stepReq = rateDone & held;
                end
            end
            default: begin
                stepReq = 1'b0;
            end
        endcase
    end

    // Repeat timer, free-running only while a hold is in progress.
    always_ff @(posedge iCLK) begin
        if (iRST || tmrClr) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign kNext = kStep(kReg, keyBus.iDEC_SW);

    // Gain register; the update pulse fires only on an actual value change.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            kReg <= K_INIT;
            kUpd <= 1'b0;
        end else begin
            kUpd <= 1'b0;
            if (stepReq && (kNext != kReg)) begin
                kReg <= kNext;
                kUpd <= 1'b1;
            end
        end
    end

    assign keyBus.oK     = kReg;
    assign keyBus.oK_UPD = kUpd;
    assign keyBus.oSAT   = ((kReg == K_MAX) && !keyBus.iDEC_SW) || ((kReg == K_MIN) && keyBus.iDEC_SW);

endmodule

// File: tb/tb_k_const_ctrl.sv
// Self-checking bench for k_const_ctrl against an age/run-length reference model.
module tb_k_const_ctrl;
    import k_ctrl_pkg::*;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 3;
    localparam logic [7:0] KI = 8'd1;

    logic iCLK = 1'b0;
    logic iRST;

    k_const_ctrl_if bus();

    k_const_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .K_INIT         (KI)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .keyBus(bus)
    );

    always #5 iCLK = ~iCLK;

    int nAsserts;
    int nFails;
    int edgeNo;

    // Reference model state
    logic [7:0] mK;
    logic       mUpd;
    logic       hist1;
    logic       hist2;
    logic       mLevel;
    int         mRun;
    logic       mPressEv;
    bit         mActive;
    int         mAge;

    function automatic logic expSat();
        return (mK == 8'd255 && !bus.iDEC_SW) || (mK == 8'd0 && bus.iDEC_SW);
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that edge, then settle.
    task automatic cyc();
        bit step;
        @(posedge iCLK);
        edgeNo++;
        if (iRST) begin
            mK = KI; mUpd = 1'b0; hist1 = 1'b1; hist2 = 1'b1;
            mLevel = 1'b1; mRun = 0; mPressEv = 1'b0; mActive = 1'b0; mAge = 0;
        end else begin
            step = 1'b0;
            if (mActive) begin
                if (mLevel || !bus.iEN_SW) begin
                    mActive = 1'b0;
                end else begin
                    mAge++;
                    if (mAge >= RD && ((mAge - RD) % RR) == 0) step = 1'b1;
                end
            end else if (mPressEv && bus.iEN_SW) begin
                mActive = 1'b1;
                mAge = 0;
                step = 1'b1;
            end
            mUpd = 1'b0;
            if (step) begin
                if (bus.iDEC_SW && mK != 8'd0) begin
                    mK = mK - 8'd1; mUpd = 1'b1;
                end else if (!bus.iDEC_SW && mK != 8'd255) begin
                    mK = mK + 8'd1; mUpd = 1'b1;
                end
            end
            mPressEv = 1'b0;
            if (hist2 != mLevel) begin
                mRun++;
                if (mRun == DB) begin
                    mLevel = hist2; mRun = 0; mPressEv = !hist2;
                end
            end else begin
                mRun = 0;
            end
            hist2 = hist1;
            hist1 = bus.iKEY;
        end
        #1;
    endtask

    task automatic doReset();
        iRST = 1'b1;
        cyc();
        cyc();
        iRST = 1'b0;
    endtask

    task automatic test_reset();
        bus.iKEY = 1'b1; bus.iEN_SW = 1'b1; bus.iDEC_SW = 1'b0;
        doReset();
        nAsserts++;
        if (bus.oK !== 8'd1 || bus.oK_UPD !== 1'b0 || bus.oSAT !== 1'b0) begin
            nFails++;
            $display("FAIL reset oK=%0d upd=%0b sat=%0b expected 1/0/0", bus.oK, bus.oK_UPD, bus.oSAT);
        end
    endtask

    task automatic test_single_press();
        int e0, updEdge, updCnt;
        updEdge = -1; updCnt = 0; e0 = 0;
        bus.iDEC_SW = 1'b0; bus.iKEY = 1'b1;
        doReset();
        for (int i = 0; i < 30; i++) begin
            bus.iKEY = (i >= 3 && i <= 7) ? 1'b0 : 1'b1;
            cyc();
            if (i == 3) e0 = edgeNo;
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL press_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
            if (bus.oK_UPD === 1'b1) begin
                updCnt++;
                updEdge = edgeNo;
            end
        end
        nAsserts++;
        if (updCnt != 1 || updEdge != e0 + DB + 2 || bus.oK !== 8'd2) begin
            nFails++;
            $display("FAIL press_latency pulses=%0d at=%0d oK=%0d expected 1 at %0d oK=2",
                     updCnt, updEdge, bus.oK, e0 + DB + 2);
        end
    endtask

    task automatic test_bounce();
        int updCnt;
        updCnt = 0;
        doReset();
        for (int i = 0; i < 30; i++) begin
            bus.iKEY = ((i <= 2) || (i >= 4 && i <= 6)) ? 1'b0 : 1'b1;
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL bounce_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
            if (bus.oK_UPD === 1'b1) updCnt++;
        end
        nAsserts++;
        if (updCnt != 0 || bus.oK !== 8'd1) begin
            nFails++;
            $display("FAIL bounce pulses=%0d oK=%0d expected 0 pulses oK=1", updCnt, bus.oK);
        end
    endtask

    task automatic test_hold();
        int updEdges[$];
        logic [7:0] updVals[$];
        bus.iDEC_SW = 1'b0;
        doReset();
        for (int i = 0; i < 45; i++) begin
            bus.iKEY = (i < 30) ? 1'b0 : 1'b1;
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL hold_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
            if (bus.oK_UPD === 1'b1) begin
                updEdges.push_back(edgeNo);
                updVals.push_back(bus.oK);
            end
        end
        nAsserts++;
        if (updEdges.size() < 4) begin
            nFails++;
            $display("FAIL hold_count pulses=%0d expected at least 4", updEdges.size());
        end else if (updEdges[1] - updEdges[0] != RD || updEdges[2] - updEdges[1] != RR ||
                     updEdges[3] - updEdges[2] != RR || updVals[0] !== 8'd2 || updVals[1] !== 8'd3 ||
                     updVals[2] !== 8'd4 || updVals[3] !== 8'd5) begin
            nFails++;
            $display("FAIL hold_schedule gaps=%0d,%0d,%0d vals=%0d,%0d,%0d,%0d expected 8,3,3 and 2,3,4,5",
                     updEdges[1] - updEdges[0], updEdges[2] - updEdges[1], updEdges[3] - updEdges[2],
                     updVals[0], updVals[1], updVals[2], updVals[3]);
        end
    endtask

    task automatic test_saturate();
        int satPulses;
        satPulses = 0;
        bus.iDEC_SW = 1'b0;
        doReset();
        for (int i = 0; i < 891; i++) begin
            if (i < 800)      bus.iKEY = 1'b0;
            else if (i < 820) bus.iKEY = 1'b1;
            else if (i < 840) bus.iKEY = 1'b0;
            else if (i < 860) bus.iKEY = 1'b1;
            else if (i < 866) bus.iKEY = 1'b0;
            else              bus.iKEY = 1'b1;
            bus.iDEC_SW = (i >= 860) ? 1'b1 : 1'b0;
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL sat_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
            if (i >= 820 && i < 860 && bus.oK_UPD === 1'b1) satPulses++;
            if (i == 819) begin
                nAsserts++;
                if (bus.oK !== 8'd255 || bus.oSAT !== 1'b1) begin
                    nFails++;
                    $display("FAIL sat_top oK=%0d sat=%0b expected 255/1", bus.oK, bus.oSAT);
                end
            end
            if (i == 859) begin
                nAsserts++;
                if (satPulses != 0 || bus.oK !== 8'd255) begin
                    nFails++;
                    $display("FAIL sat_press pulses=%0d oK=%0d expected 0 pulses oK=255", satPulses, bus.oK);
                end
            end
        end
        nAsserts++;
        if (bus.oK !== 8'd254 || bus.oSAT !== 1'b0) begin
            nFails++;
            $display("FAIL sat_dec oK=%0d sat=%0b expected 254/0", bus.oK, bus.oSAT);
        end
    endtask

    task automatic test_enable();
        int earlyPulses, totalPulses;
        earlyPulses = 0; totalPulses = 0;
        bus.iDEC_SW = 1'b0;
        doReset();
        for (int i = 0; i < 90; i++) begin
            bus.iEN_SW = (i >= 20) ? 1'b1 : 1'b0;
            bus.iKEY = (i < 40 || (i >= 60 && i < 66)) ? 1'b0 : 1'b1;
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL enable_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
            if (bus.oK_UPD === 1'b1) begin
                totalPulses++;
                if (i < 60) earlyPulses++;
            end
        end
        nAsserts++;
        if (earlyPulses != 0 || totalPulses != 1 || bus.oK !== 8'd2) begin
            nFails++;
            $display("FAIL enable early=%0d total=%0d oK=%0d expected 0/1/2", earlyPulses, totalPulses, bus.oK);
        end
        bus.iEN_SW = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r, updEdge;
        logic [7:0] updVal;
        updEdge = -1; updVal = 8'd0;
        bus.iDEC_SW = 1'b0;
        doReset();
        bus.iKEY = 1'b0;
        for (int i = 0; i < 300 && mK != 8'd40; i++) begin
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL rstmid_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
        end
        nAsserts++;
        if (bus.oK !== 8'd40) begin
            nFails++;
            $display("FAIL rstmid_reach oK=%0d expected 40 within bound", bus.oK);
        end
        iRST = 1'b1;
        cyc();
        iRST = 1'b0;
        r = edgeNo;
        nAsserts++;
        if (bus.oK !== 8'd1 || bus.oK_UPD !== 1'b0) begin
            nFails++;
            $display("FAIL rstmid_reset oK=%0d upd=%0b expected 1/0", bus.oK, bus.oK_UPD);
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.oK_UPD === 1'b1 && updEdge < 0) begin
                updEdge = edgeNo;
                updVal = bus.oK;
            end
        end
        nAsserts++;
        if (updEdge != r + DB + 3 || updVal !== 8'd2) begin
            nFails++;
            $display("FAIL rstmid_repress step at %0d val=%0d expected %0d val=2", updEdge, updVal, r + DB + 3);
        end
        bus.iKEY = 1'b1;
    endtask

    task automatic test_random();
        int runLeft;
        runLeft = 0;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            if (runLeft == 0) begin
                bus.iKEY = ~bus.iKEY;
                runLeft = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
                bus.iDEC_SW = 1'($urandom_range(0, 1));
                bus.iEN_SW = ($urandom_range(0, 9) != 0);
            end
            runLeft--;
            if ($urandom_range(0, 29) == 0) bus.iDEC_SW = ~bus.iDEC_SW;
            iRST = ($urandom_range(0, 249) == 0);
            cyc();
            nAsserts++;
            if (bus.oK !== mK || bus.oK_UPD !== mUpd || bus.oSAT !== expSat()) begin
                nFails++;
                $display("FAIL random_cycle edge=%0d oK=%0d exp=%0d upd=%0b exp=%0b sat=%0b exp=%0b",
                         edgeNo, bus.oK, mK, bus.oK_UPD, mUpd, bus.oSAT, expSat());
            end
        end
        iRST = 1'b0;
    endtask

    initial begin
        nAsserts = 0;
        nFails = 0;
        edgeNo = 0;
        iRST = 1'b1;
        bus.iKEY = 1'b1;
        bus.iEN_SW = 1'b1;
        bus.iDEC_SW = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_hold();
        test_saturate();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
